sprite_mixer: RTL
=================

Name: sprite_mixer

Overview:
Parametrised N-channel sprite compositor for the VGA pixel pipeline. It replaces the per-character, hand-duplicated address, hit-delay and priority logic in the top level with one generic block. For each channel it computes the hit window and the sprite-sheet ROM address, supporting scaling, horizontal flip and animation-frame offsets. It pipelines the hit flags to match ROM latency, resolves priority and the transparency key over the background colour, and latches per-frame sprite-overlap flags. It sits between the vga timing block and pattern_gen.

Parameters:
NUM_SPRITES, 2, number of sprite channels; channel 0 has highest priority.
ADDR_W, 14, width of each per-channel ROM address.
SCALE_SHIFT, 1, display scale = 2^SCALE_SHIFT screen pixels per sheet pixel.
ROM_LAT, 1, cycles from rom_addr registered to rom_rgb valid.
TRANSPARENT, 6'b110011, colour key treated as see-through.

Ports:
clk  in  1  pixel clock (PLL output)
rst_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse once per frame (from vga)
pixel_valid  in  1  visible-area flag aligned with col/row
col  in  10  current pixel column
row  in  10  current pixel row
spr_en  in  NUM_SPRITES  per-channel enable
spr_flip  in  NUM_SPRITES  1 = mirror horizontally within frame
spr_x  in  10*NUM_SPRITES  top-left column, channel i at [10i+9:10i]
spr_y  in  10*NUM_SPRITES  top-left row
spr_w  in  8*NUM_SPRITES  frame width in sheet pixels (≥1)
spr_h  in  8*NUM_SPRITES  frame height in sheet pixels (≥1)
anim_col  in  8*NUM_SPRITES  frame column offset in sheet
anim_row  in  8*NUM_SPRITES  frame row offset in sheet
sheet_w  in  8*NUM_SPRITES  sheet row stride in sheet pixels
rom_addr  out  ADDR_W*NUM_SPRITES  registered per-channel ROM address
rom_rgb  in  6*NUM_SPRITES  per-channel ROM data
bg_rgb  in  6  background colour, caller-aligned to the rom_rgb cycle
out_rgb  out  6  composited colour
out_valid  out  1  delayed pixel_valid
collision  out  NUM_SPRITES  channels involved in an opaque overlap during the last completed frame

Behaviour:
- Reset (async, rst_n=0): rom_addr, out_rgb, out_valid, collision, all pipeline flags and the accumulator go to 0 immediately. The first valid output appears LATENCY cycles after the first pixel presented post-release.
- LATENCY = ROM_LAT + 2.
  - Pixel at cycle t: rom_addr registered at t+1.
  - rom_rgb and bg_rgb sampled at t+1+ROM_LAT.
  - out_rgb/out_valid registered at t+2+ROM_LAT.
- Hit per channel i:
  - en_i && pixel_valid && spr_x ≤ col < spr_x + (w<<SCALE_SHIFT) && spr_y ≤ row < spr_y + (h<<SCALE_SHIFT).
  - Compares use 11-bit sums, so a sprite crossing column/row 1023 neither wraps nor hits at low coordinates.
- Address on hit:
  - lx = (col−x)>>SCALE_SHIFT; ly = (row−y)>>SCALE_SHIFT.
  - If flip, lx' = w−1−lx (mirrors within the current frame only), else lx' = lx.
  - addr = (ly+anim_row)*sheet_w + lx' + anim_col, truncated to ADDR_W.
  - No hit: addr = 0.
- Hit flags and pixel_valid are delayed ROM_LAT+1 stages so they align with rom_rgb.
- Compositing (on the aligned stage):
  - out_rgb = rom_rgb of the lowest-index channel that hits and whose rom_rgb ≠ TRANSPARENT.
  - If no such channel, out_rgb = bg_rgb.
  - If the aligned pixel_valid = 0, out_rgb = 0.
- Collision accumulator:
  - Each aligned cycle in which ≥2 channels are opaque-hit ORs those channels' bits into the accumulator.
  - On frame_tick: collision ← accumulator, then the accumulator clears.
  - An overlap in the same cycle as frame_tick is credited to the new accumulator, not to collision.
  - collision holds its value for the whole next frame.
- spr_* inputs are sampled every cycle; the caller changes them only while pixel_valid = 0 (vblank). Behaviour on mid-line changes is defined per-cycle as above, with no glitch protection.
- NUM_SPRITES = 1: collision is constant 0.

Test Plan:
- Reset: assert rst_n=0 mid-frame with a sprite opaque-hitting → out_rgb, out_valid, collision, rom_addr all 0 the same cycle; first out_valid=1 appears exactly ROM_LAT+2 cycles after the first valid pixel post-release.
- Address/scale: ch0 x=50, y=290, w=23, h=30, anim_col=23, sheet_w=69, no flip, SCALE_SHIFT=1; col=52, row=292 → rom_addr0 = 1*69+1+23 = 93. Same pixel with flip → 1*69+21+23 = 113.
- Priority/transparency: both channels hit, rom_rgb0=6'b110011, rom_rgb1=6'h0A, bg=6'h01 → out_rgb=6'h0A. With rom_rgb0=6'h3F → 6'h3F. With rom_rgb1 also keyed → 6'h01.
- Edge clipping: x=1000, w=23, SCALE_SHIFT=1 → hit at col 1000..1023, no hit at col 0..21. pixel_valid=0 inside the window → out_rgb=0.
- Collision: opaque overlap of ch0/ch1 during frame N → collision=2'b11 after frame_tick N+1, and collision=2'b00 after frame_tick N+2 with no overlap. An overlap coinciding with frame_tick appears only at the following tick.
- Latency sweep: ROM_LAT=1 and ROM_LAT=2 against a model ROM → out_rgb matches the reference-model pixel stream offset by ROM_LAT+2 over a full 640x480 frame.

Source files
------------

// File: rtl/sprite_mixer.sv
// sprite_mixer: N-channel sprite compositor for the VGA pixel pipeline.
// Per channel it decodes the hit window, forms the sprite-sheet ROM address
// (with scaling, horizontal flip and animation-frame offset), delays the hit
// flags to line up with ROM data, then resolves priority and the transparency
// key over the background colour. Opaque overlaps are gathered per frame.
//
// Ports:
//   clk, rst_n           pixel clock, async active-low reset
//   frame_tick           one-cycle pulse per frame
//   pixel_valid/col/row  current pixel and visible-area flag
//   spr_*, anim_*, sheet_w  per-channel packed geometry (channel i in slice i)
//   rom_addr             registered per-channel sheet address
//   rom_rgb, bg_rgb      ROM data and background, both on the aligned cycle
//   out_rgb, out_valid   composited pixel, ROM_LAT+2 cycles after the input
//   collision            channels in an opaque overlap during last frame
module sprite_mixer #(
  parameter int         NUM_SPRITES = 2,
  parameter int         ADDR_W      = 14,
  parameter int         SCALE_SHIFT = 1,
  parameter int         ROM_LAT     = 1,
  parameter logic [5:0] TRANSPARENT = 6'b110011
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic                          pixel_valid,
  input  logic [9:0]                    col,
  input  logic [9:0]                    row,
  input  logic [NUM_SPRITES-1:0]        spr_en,
  input  logic [NUM_SPRITES-1:0]        spr_flip,
  input  logic [10*NUM_SPRITES-1:0]     spr_x,
  input  logic [10*NUM_SPRITES-1:0]     spr_y,
  input  logic [8*NUM_SPRITES-1:0]      spr_w,
  input  logic [8*NUM_SPRITES-1:0]      spr_h,
  input  logic [8*NUM_SPRITES-1:0]      anim_col,
  input  logic [8*NUM_SPRITES-1:0]      anim_row,
  input  logic [8*NUM_SPRITES-1:0]      sheet_w,
  output logic [ADDR_W*NUM_SPRITES-1:0] rom_addr,
  input  logic [6*NUM_SPRITES-1:0]      rom_rgb,
  input  logic [5:0]                    bg_rgb,
  output logic [5:0]                    out_rgb,
  output logic                          out_valid,
  output logic [NUM_SPRITES-1:0]        collision
);

  // One extra bit (plus the scale) keeps x + (w << SCALE_SHIFT) from wrapping
  // past column 1023 back into low coordinates.
  localparam int EW = 11 + SCALE_SHIFT;

  logic [NUM_SPRITES-1:0]                hit_c;
  logic [ADDR_W*NUM_SPRITES-1:0]         addr_c;
  logic [ROM_LAT:0][NUM_SPRITES-1:0]     hit_pipe;
  logic [ROM_LAT:0]                      vld_pipe;
  logic [NUM_SPRITES-1:0]                hit_al;
  logic                                  vld_al;
  logic [NUM_SPRITES-1:0]                opaque;
  logic [NUM_SPRITES-1:0]                overlap;
  logic [NUM_SPRITES-1:0]                coll_acc;
  logic [5:0]                            mix_rgb;

  assign hit_al = hit_pipe[ROM_LAT];
  assign vld_al = vld_pipe[ROM_LAT];

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
    logic [9:0]    x0, y0;
    logic [7:0]    w, h;
    logic [EW-1:0] x_end, y_end;
    logic [9:0]    lx, ly, lx_f;

    assign x0 = spr_x[10*g +: 10];
    assign y0 = spr_y[10*g +: 10];
    assign w  = spr_w[8*g +: 8];
    assign h  = spr_h[8*g +: 8];

    assign x_end = EW'(x0) + (EW'(w) << SCALE_SHIFT);
    assign y_end = EW'(y0) + (EW'(h) << SCALE_SHIFT);

    assign hit_c[g] = spr_en[g] & pixel_valid &
                      (EW'(col) >= EW'(x0)) & (EW'(col) < x_end) &
                      (EW'(row) >= EW'(y0)) & (EW'(row) < y_end);

    assign lx   = (col - x0) >> SCALE_SHIFT;
    assign ly   = (row - y0) >> SCALE_SHIFT;
    // Flip mirrors inside the current animation frame, not the whole sheet.
    assign lx_f = spr_flip[g] ? ({2'b00, w} - 10'd1 - lx) : lx;

    // Arithmetic at ADDR_W width gives the same result as truncating the
    // full-width address.
    assign addr_c[ADDR_W*g +: ADDR_W] = hit_c[g] ?
        ((ADDR_W'(ly) + ADDR_W'(anim_row[8*g +: 8])) * ADDR_W'(sheet_w[8*g +: 8])
         + ADDR_W'(lx_f) + ADDR_W'(anim_col[8*g +: 8])) : '0;

    assign opaque[g] = hit_al[g] & (rom_rgb[6*g +: 6] != TRANSPARENT);
  end

  // Lowest index wins: scan from the top so channel 0 is applied last.
  always_comb begin
    mix_rgb = bg_rgb;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) mix_rgb = rom_rgb[6*i +: 6];
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign overlap = (|(opaque & (opaque - NUM_SPRITES'(1)))) ? opaque : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      hit_pipe  <= '0;
      vld_pipe  <= '0;
      out_rgb   <= '0;
      out_valid <= 1'b0;
      coll_acc  <= '0;
      collision <= '0;
    end else begin
      rom_addr    <= addr_c;
      hit_pipe[0] <= hit_c;
      vld_pipe[0] <= pixel_valid;
      for (int k = 1; k <= ROM_LAT; k++) begin
        hit_pipe[k] <= hit_pipe[k-1];
        vld_pipe[k] <= vld_pipe[k-1];
      end
      out_valid <= vld_al;
      out_rgb   <= vld_al ? mix_rgb : 6'd0;
      // A same-cycle overlap seeds the fresh accumulator for the new frame.
      if (frame_tick) begin
        collision <= coll_acc;
        coll_acc  <= overlap;
      end else begin
        coll_acc  <= coll_acc | overlap;
      end
    end
  end

endmodule
